mux_rr_sched: RTL and testbench

MUX_RR_SCHED -- requirements
Module: mux_rr_sched

---
 rtl/mux_sched_pkg.sv | 12 +
 rtl/mux_rr_sched_rr_pick.sv | 24 ++
 rtl/mux_rr_sched.sv | 127 ++++++++++++
 tb/tb_mux_rr_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin 4:1 mux scheduler.
package mux_sched_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DWELL = 2'd2
  } state_t;

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// Rotated priority search: first set request strictly after 'last', wrapping,
// with 'last' itself checked at lowest priority.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       winner,
  output logic             found
);

  // Walk offsets from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[2'(last + 2'(k))]) begin
        winner = 2'(last + 2'(k));
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler owning a shared 4:1 mux: timed or manual-step grant
// rotation with hold, early release on request drop, and a registered mux output.
module mux_rr_sched #(
  parameter int DWELL_W = 8,
  parameter int N_REQ   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   data_in,
  input  logic               auto_en,
  input  logic               hold,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell_cfg,
  output logic [1:0]         sel,
  output logic [N_REQ-1:0]   grant,
  output logic               grant_valid,
  output logic               y
);
  import mux_sched_pkg::*;

  state_t               state_reg, state_next;
  logic [1:0]           sel_reg, sel_next;
  logic [N_REQ-1:0]     grant_reg, grant_next;
  logic                 gv_reg, gv_next;
  logic                 y_reg, y_next;
  logic [DWELL_W-1:0]   cnt_reg, cnt_next;
  logic                 step_q_reg;
  logic [1:0]           last_reg, last_next;

  logic [1:0]           winner;
  logic                 found;
  logic                 step_rise;
  logic                 end_grant;

  rr_pick u_pick (
    .req    (req),
    .last   (last_reg),
    .winner (winner),
    .found  (found)
  );

  assign step_rise = step & ~step_q_reg;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    gv_next    = gv_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    end_grant  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req) state_next = ARB;
      end
      ARB: begin
        if (found) begin
          state_next         = DWELL;
          sel_next           = winner;
          grant_next         = '0;
          grant_next[winner] = 1'b1;
          gv_next            = 1'b1;
          last_next          = winner;
          cnt_next           = dwell_cfg;
        end else begin
          state_next = IDLE;
        end
      end
      DWELL: begin
        // Losing the owner's request beats hold; hold beats both timer and step.
        if (!req[sel_reg]) begin
          end_grant = 1'b1;
        end else if (hold) begin
          end_grant = 1'b0;
        end else if (auto_en) begin
          if (cnt_reg == '0) end_grant = 1'b1;
          else               cnt_next  = cnt_reg - DWELL_W'(1);
        end else if (step_rise) begin
          end_grant = 1'b1;
        end

        if (end_grant) begin
          state_next = (|req) ? ARB : IDLE;
          grant_next = '0;
          gv_next    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        gv_next    = 1'b0;
      end
    endcase

    y_next = (state_next == DWELL) ? data_in[sel_next] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      sel_reg    <= 2'd0;
      grant_reg  <= '0;
      gv_reg     <= 1'b0;
      y_reg      <= 1'b0;
      cnt_reg    <= '0;
      step_q_reg <= 1'b0;
      last_reg   <= 2'd3;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      grant_reg  <= grant_next;
      gv_reg     <= gv_next;
      y_reg      <= y_next;
      cnt_reg    <= cnt_next;
      step_q_reg <= step;
      last_reg   <= last_next;
    end
  end

  assign sel         = sel_reg;
  assign grant       = grant_reg;
  assign grant_valid = gv_reg;
  assign y           = y_reg;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: grant-order scoreboard plus directed
// checks on latency, manual stepping, hold, request drop, mux output and reset.
module tb_mux_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data_in;
  logic       auto_en;
  logic       hold;
  logic       step;
  logic [7:0] dwell_cfg;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       grant_valid;
  logic       y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int len;   // 0 = length not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   run_len = 0;
  logic gv_prev = 1'b0;

  mux_rr_sched #(.DWELL_W(8), .N_REQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .auto_en     (auto_en),
    .hold        (hold),
    .step        (step),
    .dwell_cfg   (dwell_cfg),
    .sel         (sel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .y           (y)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input int len);
    exp_t e;
    e.idx = idx;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Scoreboard: each new grant pops the next expected owner; its length is
  // checked when the grant ends.
  always @(negedge clk) begin
    if (grant_valid && !gv_prev) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected", {28'd0, grant}, 32'd0);
        cur.idx = -1;
        cur.len = 0;
      end else begin
        cur = exp_q.pop_front();
        check_val("sb_grant", {28'd0, grant}, 32'd1 << cur.idx);
        check_val("sb_sel", {30'd0, sel}, cur.idx);
      end
      run_len = 1;
      $display("grant start idx=%0d grant=%b t=%0t", cur.idx, grant, $time);
    end else if (grant_valid) begin
      run_len++;
    end
    if (!grant_valid && gv_prev && cur.len != 0)
      check_val("sb_len", run_len, cur.len);
    gv_prev = grant_valid;
  end

  task automatic wait_gv(input string tag, input logic val, input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (grant_valid == val) hit = 1'b1;
    end
    if (!hit) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_empty(input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) hit = 1'b1;
    end
    if (!hit) check_val("tmo_sb_empty", 32'd0, 32'd1);
  endtask

  // Asserts reset between clock edges and checks the outputs fall at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_gv", {31'd0, grant_valid}, 32'd0);
    check_val("rst_grant", {28'd0, grant}, 32'd0);
    check_val("rst_y", {31'd0, y}, 32'd0);
    check_val("rst_sel", {30'd0, sel}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ok_cnt;
    logic [3:0] pat_gnt [6];
    logic       pat_gv  [6];
    logic [3:0] y_din   [4];
    logic       y_exp   [4];

    rst = 1'b1; req = '0; data_in = '0; auto_en = 1'b1; hold = 1'b0;
    step = 1'b0; dwell_cfg = '0;
    #2 rst = 1'b0;
    #1;
    check_val("init_gv", {31'd0, grant_valid}, 32'd0);
    check_val("init_grant", {28'd0, grant}, 32'd0);
    check_val("init_sel", {30'd0, sel}, 32'd0);
    check_val("init_y", {31'd0, y}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Full rotation, 3-cycle grants with one-cycle ARB bubble.
    dwell_cfg = 8'd2;
    for (int i = 0; i < 5; i++) push_exp(i % 4, 3);
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    check_val("lat_arb", {31'd0, grant_valid}, 32'd0);
    @(negedge clk);
    check_val("lat_gv", {31'd0, grant_valid}, 32'd1);
    check_val("lat_grant", {28'd0, grant}, 32'd1);
    wait_empty(80);
    wait_gv("tmo_rot_end", 1'b0, 10);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    check_val("rot_idle", {31'd0, grant_valid}, 32'd0);

    // One-cycle grants alternating between requesters 0 and 2.
    do_reset();
    dwell_cfg = 8'd0;
    push_exp(0, 1); push_exp(2, 1); push_exp(0, 1);
    pat_gv  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pat_gnt = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
    req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("alt_gv", {31'd0, grant_valid}, {31'd0, pat_gv[i]});
      check_val("alt_grant", {28'd0, grant}, {28'd0, pat_gnt[i]});
    end
    req = 4'b0000;
    wait_gv("tmo_alt_end", 1'b0, 5);

    // Manual step mode, then hold blocking a step.
    do_reset();
    auto_en = 1'b0;
    push_exp(0, 0); push_exp(1, 0); push_exp(0, 0);
    req = 4'b0011;
    wait_gv("tmo_man_start", 1'b1, 10);
    check_val("man_first", {28'd0, grant}, 32'd1);
    ok_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant_valid && grant == 4'b0001) ok_cnt++;
    end
    check_val("man_persist", ok_cnt, 32'd20);
    step = 1'b1;
    @(negedge clk);
    check_val("step_arb", {31'd0, grant_valid}, 32'd0);
    step = 1'b0;
    @(negedge clk);
    check_val("step_grant", {28'd0, grant}, 32'd2);
    hold = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
    check_val("hold_gv", {31'd0, grant_valid}, 32'd1);
    check_val("hold_grant", {28'd0, grant}, 32'd2);
    hold = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    check_val("step2_arb", {31'd0, grant_valid}, 32'd0);
    step = 1'b0;
    @(negedge clk);
    check_val("step2_grant", {28'd0, grant}, 32'd1);
    req = 4'b0000;
    wait_gv("tmo_man_end", 1'b0, 5);
    auto_en = 1'b1;

    // Owner drops its request mid-grant.
    do_reset();
    dwell_cfg = 8'd10;
    push_exp(1, 0); push_exp(3, 0);
    req = 4'b0010;
    wait_gv("tmo_drop_start", 1'b1, 10);
    check_val("drop_first", {28'd0, grant}, 32'd2);
    req = 4'b1010;
    repeat (2) @(negedge clk);
    check_val("drop_keep", {28'd0, grant}, 32'd2);
    req = 4'b1000;
    @(negedge clk);
    check_val("drop_arb", {31'd0, grant_valid}, 32'd0);
    @(negedge clk);
    check_val("drop_grant", {28'd0, grant}, 32'd8);
    req = 4'b0000;
    @(negedge clk);
    check_val("drop_idle_gv", {31'd0, grant_valid}, 32'd0);
    check_val("drop_idle_grant", {28'd0, grant}, 32'd0);
    @(negedge clk);
    check_val("drop_idle_stay", {31'd0, grant_valid}, 32'd0);

    // Registered mux output follows data_in[sel] during the grant.
    dwell_cfg = 8'd20;
    data_in = 4'b0100;
    push_exp(2, 0);
    req = 4'b0100;
    wait_gv("tmo_y_start", 1'b1, 10);
    check_val("y_sel", {30'd0, sel}, 32'd2);
    check_val("y_first", {31'd0, y}, 32'd1);
    y_din = '{4'b0000, 4'b0100, 4'b1011, 4'b0100};
    y_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      data_in = y_din[i];
      @(negedge clk);
      check_val("y_follow", {31'd0, y}, {31'd0, y_exp[i]});
    end

    // Reset mid-grant, then restart from the lowest requester.
    check_val("pre_rst_gv", {31'd0, grant_valid}, 32'd1);
    do_reset();
    push_exp(1, 0);
    req = 4'b0110;
    wait_gv("tmo_rst_start", 1'b1, 10);
    check_val("rst_first", {28'd0, grant}, 32'd2);
    req = 4'b0000;
    wait_gv("tmo_rst_end", 1'b0, 5);

    repeat (3) @(negedge clk);
    check_val("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
